mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single 16-bit synchronous memory port between two requesters: the CPU (requester 0) and a peripheral bus master such as a display fetch or DMA engine (requester 1). Sits between both masters and the memory, replacing the CPU's direct Mem_Addr/Mem_Write connection. Arbitration is fixed priority with a starvation guard. Read data is returned to the owning requester through a tagged latency pipeline.

Parameters:
ADDR_W, 16, width of address buses
DATA_W, 16, width of data buses
READ_LAT, 1, memory read latency in cycles, from address presented to data valid; must be >= 1
STARVE_LIMIT, 4, number of consecutive lost arbitrations after which the device wins; must be >= 1

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Cpu_Req  input  1  CPU access request; held until Cpu_Ack
Cpu_Addr  input  ADDR_W  CPU address; stable while Cpu_Req=1
Cpu_Write  input  1  1 = write, 0 = read
Cpu_WData  input  DATA_W  CPU write data
Cpu_Ack  output  1  one-cycle pulse: request consumed
Cpu_RValid  output  1  one-cycle pulse: Cpu_RData valid
Cpu_RData  output  DATA_W  read data to CPU
Dev_Req, Dev_Addr, Dev_Write, Dev_WData, Dev_Ack, Dev_RValid, Dev_RData  same directions, widths and meanings as the CPU group, for the device
Mem_Addr  output  ADDR_W  memory address, registered
Mem_Write  output  1  memory write enable, registered
Mem_WData  output  DATA_W  memory write data, registered
Mem_RData  input  DATA_W  memory read data, valid READ_LAT cycles after address
Busy  output  1  1 while state = ACCESS

Behaviour:
- Clock domain: one clock, Clock. Reset is synchronous and active-high. All state and outputs are updated on the rising edge of Clock.
- States: IDLE and ACCESS. From IDLE, if any request is pending, go to ACCESS; otherwise stay in IDLE. ACCESS always returns to IDLE. Throughput is one access per 2 cycles.
- Arbitration in IDLE, cycle t:
  - Only one request: that requester wins.
  - Both requests: CPU wins, unless starve_cnt == STARVE_LIMIT, in which case the device wins.
  - On the edge that ends cycle t, the winner's Addr, Write and WData are registered onto the Mem_* outputs, and the owner is latched.
- ACCESS, cycle t+1:
  - The owner's Ack is 1 for this cycle only.
  - Mem_Write equals the owner's Write in this cycle only. It is 0 in every IDLE cycle.
  - Mem_Addr holds its value until the next grant.
  - Requesters may change or drop Req from cycle t+2.
- starve_cnt:
  - Increments on each IDLE arbitration where Dev_Req=1 and the CPU wins.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on a device grant.
  - Is unchanged otherwise.
- Read return:
  - A READ_LAT-deep shift register carries {valid, owner} for each read grant.
  - Owner's RValid is asserted in cycle t+1+READ_LAT.
  - The matching RData equals Mem_RData combinationally in that cycle. The non-owner's RValid stays 0.
  - Writes never produce RValid.
  - With READ_LAT > 1, returns from consecutive reads stay ordered and carry the correct tags.
- Req dropped before Ack: undefined use, but the arbiter still completes the latched access.
- Reset values:
  - state IDLE, starve_cnt 0, read pipeline cleared.
  - Mem_Addr 0, Mem_Write 0, Mem_WData 0.
  - Both Ack 0, both RValid 0, Busy 0.
  - Reset mid-ACCESS or with reads in flight discards them: no RValid is emitted afterwards and Mem_Write is 0 from the next cycle.

Optional Feature:
MEM_ARB_RR_EN. When defined, arbitration on simultaneous requests becomes round-robin: the requester not granted most recently wins, and after reset the CPU is favoured first. starve_cnt is not implemented. When undefined, fixed priority with the starvation guard applies as described above. Single-request behaviour, timing and read return are identical in both builds.

Test Plan:
1. Hold Reset=1 for 2 cycles with both Reqs=1 -> all outputs 0 throughout and 1 cycle after release; first Ack appears at release+2.
2. CPU read only, Cpu_Addr=0x0040, memory[0x0040]=0xBEEF, READ_LAT=1, Req at t -> Mem_Addr=0x0040 and Cpu_Ack=1 at t+1, Cpu_RValid=1 with Cpu_RData=0xBEEF at t+2, Dev_RValid=0.
3. Device write of 0x1234 to 0x00FF -> Mem_Write=1 for exactly cycle t+1 with Mem_WData=0x1234, Dev_Ack at t+1, no RValid on either side.
4. Both request at t, single-shot -> Cpu_Ack at t+1, Dev_Ack at t+3; under MEM_ARB_RR_EN with prior grant to the CPU -> Dev_Ack at t+1, Cpu_Ack at t+3.
5. CPU continuously requesting, device requesting from t, STARVE_LIMIT=4 -> device loses at t, t+2, t+4, t+6; wins at t+8; Dev_Ack at t+9; starve_cnt=0 at t+9.
6. CPU read granted at t, READ_LAT=2, Reset=1 in cycle t+1 -> no Cpu_RValid at t+3, Mem_Write=0, state IDLE at t+2.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: groups the two requester ports and the memory port of the
// arbiter.
//   Cpu_* / Dev_* : request, address, write flag and write data in; ack,
//                   read-valid and read data out
//   Mem_*         : registered address, write enable and write data out;
//                   read data in
//   Busy          : arbiter is in its access cycle
// Modports:
//   slave  - the arbiter side
//   master - the requester/memory environment side
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              Cpu_Req;
  logic [ADDR_W-1:0] Cpu_Addr;
  logic              Cpu_Write;
  logic [DATA_W-1:0] Cpu_WData;
  logic              Cpu_Ack;
  logic              Cpu_RValid;
  logic [DATA_W-1:0] Cpu_RData;

  logic              Dev_Req;
  logic [ADDR_W-1:0] Dev_Addr;
  logic              Dev_Write;
  logic [DATA_W-1:0] Dev_WData;
  logic              Dev_Ack;
  logic              Dev_RValid;
  logic [DATA_W-1:0] Dev_RData;

  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Write;
  logic [DATA_W-1:0] Mem_WData;
  logic [DATA_W-1:0] Mem_RData;
  logic              Busy;

  modport slave (
    input  Cpu_Req, Cpu_Addr, Cpu_Write, Cpu_WData,
    output Cpu_Ack, Cpu_RValid, Cpu_RData,
    input  Dev_Req, Dev_Addr, Dev_Write, Dev_WData,
    output Dev_Ack, Dev_RValid, Dev_RData,
    output Mem_Addr, Mem_Write, Mem_WData,
    input  Mem_RData,
    output Busy
  );

  modport master (
    output Cpu_Req, Cpu_Addr, Cpu_Write, Cpu_WData,
    input  Cpu_Ack, Cpu_RValid, Cpu_RData,
    output Dev_Req, Dev_Addr, Dev_Write, Dev_WData,
    input  Dev_Ack, Dev_RValid, Dev_RData,
    input  Mem_Addr, Mem_Write, Mem_WData,
    output Mem_RData,
    input  Busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between the CPU
// (requester 0) and a peripheral bus master (requester 1).
//
// Ports:
//   Clock - rising-edge clock
//   Reset - synchronous, active-high reset
//   bus   - mem_arbiter_if.slave (requester groups, memory port, Busy)
//
// Operation: an IDLE cycle arbitrates and registers the winner onto Mem_*;
// the following ACCESS cycle carries the owner's Ack and Mem_Write, then the
// arbiter returns to IDLE (one access per two cycles). Reads are tagged with
// the owner in a READ_LAT-deep pipeline so the returning Mem_RData is
// steered to the correct requester.
//
// Build option: MEM_ARB_RR_EN
//   undefined - fixed priority to the CPU, with a starvation counter that
//               hands the grant to the device after STARVE_LIMIT lost
//               arbitrations in a row
//   defined   - round-robin on simultaneous requests, CPU favoured first
//               after reset; no starvation counter
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int READ_LAT     = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic          Clock,
  input logic          Reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t            state_reg;
  logic              owner_reg;      // 1 = device owns the current access
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              mem_write_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              cpu_ack_reg;
  logic              dev_ack_reg;
  logic              busy_reg;

  logic              any_req;
  logic              grant_dev;

  // Read-return tag pipeline: stage READ_LAT-1 lines up with Mem_RData.
  logic [READ_LAT-1:0] rd_valid_reg;
  logic [READ_LAT-1:0] rd_owner_reg;

`ifdef MEM_ARB_RR_EN
  logic last_dev_reg;                // 1 = device got the most recent grant
`else
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] starve_cnt_reg;
`endif

  always_comb begin
    any_req   = bus.Cpu_Req | bus.Dev_Req;
    grant_dev = 1'b0;
    if (bus.Dev_Req) begin
      if (!bus.Cpu_Req) begin
        grant_dev = 1'b1;
      end else begin
`ifdef MEM_ARB_RR_EN
        grant_dev = ~last_dev_reg;
`else
        grant_dev = (starve_cnt_reg == STARVE_MAX);
`endif
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b0;
      mem_addr_reg  <= '0;
      mem_write_reg <= 1'b0;
      mem_wdata_reg <= '0;
      cpu_ack_reg   <= 1'b0;
      dev_ack_reg   <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      // Pretend the device was served last so the CPU wins the first tie.
      last_dev_reg  <= 1'b1;
`else
      starve_cnt_reg <= '0;
`endif
    end else begin
      // Ack and write enable are single-cycle pulses of the ACCESS cycle.
      cpu_ack_reg   <= 1'b0;
      dev_ack_reg   <= 1'b0;
      mem_write_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg   <= ACCESS;
            busy_reg    <= 1'b1;
            owner_reg   <= grant_dev;
            cpu_ack_reg <= ~grant_dev;
            dev_ack_reg <= grant_dev;
            if (grant_dev) begin
              mem_addr_reg  <= bus.Dev_Addr;
              mem_write_reg <= bus.Dev_Write;
              mem_wdata_reg <= bus.Dev_WData;
            end else begin
              mem_addr_reg  <= bus.Cpu_Addr;
              mem_write_reg <= bus.Cpu_Write;
              mem_wdata_reg <= bus.Cpu_WData;
            end
`ifdef MEM_ARB_RR_EN
            last_dev_reg <= grant_dev;
`else
            if (grant_dev) begin
              starve_cnt_reg <= '0;
            end else if (bus.Dev_Req && (starve_cnt_reg != STARVE_MAX)) begin
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
`endif
          end
        end
        ACCESS: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // A read enters the tag pipeline during its ACCESS cycle, so stage k is
  // visible k+1 cycles after the address first appears on Mem_Addr.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_valid_reg <= '0;
      rd_owner_reg <= '0;
    end else begin
      rd_valid_reg[0] <= (state_reg == ACCESS) && !mem_write_reg;
      rd_owner_reg[0] <= owner_reg;
      for (int i = READ_LAT - 1; i > 0; i--) begin
        rd_valid_reg[i] <= rd_valid_reg[i-1];
        rd_owner_reg[i] <= rd_owner_reg[i-1];
      end
    end
  end

  assign bus.Mem_Addr   = mem_addr_reg;
  assign bus.Mem_Write  = mem_write_reg;
  assign bus.Mem_WData  = mem_wdata_reg;
  assign bus.Busy       = busy_reg;
  assign bus.Cpu_Ack    = cpu_ack_reg;
  assign bus.Dev_Ack    = dev_ack_reg;
  assign bus.Cpu_RValid = rd_valid_reg[READ_LAT-1] & ~rd_owner_reg[READ_LAT-1];
  assign bus.Dev_RValid = rd_valid_reg[READ_LAT-1] &  rd_owner_reg[READ_LAT-1];
  assign bus.Cpu_RData  = bus.Mem_RData;
  assign bus.Dev_RData  = bus.Mem_RData;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. u_dut uses READ_LAT=1,
// u_dut2 uses READ_LAT=2 and its own reset. Each has a small memory model;
// expected read returns are queued when a read is issued and compared when
// RValid appears.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1;
  logic rst2;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus2 ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1), .STARVE_LIMIT(4)) u_dut (
    .Clock (clk),
    .Reset (rst1),
    .bus   (bus1)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(2), .STARVE_LIMIT(4)) u_dut2 (
    .Clock (clk),
    .Reset (rst2),
    .bus   (bus2)
  );

  // Memory models (256 words, low address byte), preloaded during reset.
  logic [15:0] mem1 [0:255];
  logic [15:0] mem2 [0:255];
  logic [15:0] rd1;
  logic [15:0] rd2a;
  logic [15:0] rd2b;

  always @(posedge clk) begin
    if (rst1) begin
      mem1[8'h40] <= 16'hBEEF;
    end else if (bus1.Mem_Write) begin
      mem1[bus1.Mem_Addr[7:0]] <= bus1.Mem_WData;
    end
    rd1 <= mem1[bus1.Mem_Addr[7:0]];
  end
  assign bus1.Mem_RData = rd1;

  always @(posedge clk) begin
    if (rst2) begin
      mem2[8'h40] <= 16'hBEEF;
      mem2[8'h41] <= 16'hCAFE;
    end else if (bus2.Mem_Write) begin
      mem2[bus2.Mem_Addr[7:0]] <= bus2.Mem_WData;
    end
    rd2a <= mem2[bus2.Mem_Addr[7:0]];
    rd2b <= rd2a;
  end
  assign bus2.Mem_RData = rd2b;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic        owner;   // 1 = device
    logic [15:0] data;
  } rexp_t;

  rexp_t q1[$];
  rexp_t q2[$];

  always @(negedge clk) begin : mon1
    rexp_t e;
    if (bus1.Cpu_RValid || bus1.Dev_RValid) begin
      if (q1.size() == 0) begin
        chk("rv1_unexpected", {30'd0, bus1.Dev_RValid, bus1.Cpu_RValid}, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("rv1_tag", {30'd0, bus1.Dev_RValid, bus1.Cpu_RValid}, e.owner ? 32'd2 : 32'd1);
        chk("rv1_data", e.owner ? bus1.Dev_RData : bus1.Cpu_RData, e.data);
        $display("u_dut read return owner=%0d data=%h", e.owner, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon2
    rexp_t e;
    if (bus2.Cpu_RValid || bus2.Dev_RValid) begin
      if (q2.size() == 0) begin
        chk("rv2_unexpected", {30'd0, bus2.Dev_RValid, bus2.Cpu_RValid}, 32'd0);
      end else begin
        e = q2.pop_front();
        chk("rv2_tag", {30'd0, bus2.Dev_RValid, bus2.Cpu_RValid}, e.owner ? 32'd2 : 32'd1);
        chk("rv2_data", e.owner ? bus2.Dev_RData : bus2.Cpu_RData, e.data);
        $display("u_dut2 read return owner=%0d data=%h", e.owner, e.data);
      end
    end
  end

  initial begin
    logic exp_cpu;
    logic exp_dev;

    // ---- Reset held with both requesters active ----
    rst1 = 1'b1;
    rst2 = 1'b1;
    bus1.Cpu_Req = 1'b1; bus1.Cpu_Addr = 16'h0010; bus1.Cpu_Write = 1'b1; bus1.Cpu_WData = 16'h1111;
    bus1.Dev_Req = 1'b1; bus1.Dev_Addr = 16'h0020; bus1.Dev_Write = 1'b1; bus1.Dev_WData = 16'h2222;
    bus2.Cpu_Req = 1'b0; bus2.Cpu_Addr = 16'h0000; bus2.Cpu_Write = 1'b0; bus2.Cpu_WData = 16'h0000;
    bus2.Dev_Req = 1'b0; bus2.Dev_Addr = 16'h0000; bus2.Dev_Write = 1'b0; bus2.Dev_WData = 16'h0000;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("rst_flags_%0d", i),
          {26'd0, bus1.Cpu_Ack, bus1.Dev_Ack, bus1.Cpu_RValid, bus1.Dev_RValid, bus1.Busy, bus1.Mem_Write}, 32'd0);
      chk($sformatf("rst_addr_%0d", i), bus1.Mem_Addr, 32'd0);
      chk($sformatf("rst_wdata_%0d", i), bus1.Mem_WData, 32'd0);
      $display("reset cycle %0d checked", i);
    end
    rst1 = 1'b0;

    @(negedge clk);
    chk("rel_acks", {30'd0, bus1.Cpu_Ack, bus1.Dev_Ack}, 32'd2);
    chk("rel_addr", bus1.Mem_Addr, 32'h0010);
    chk("rel_wr", {31'd0, bus1.Mem_Write}, 32'd1);
    chk("rel_wdata", bus1.Mem_WData, 32'h1111);
    chk("rel_busy", {31'd0, bus1.Busy}, 32'd1);
    bus1.Cpu_Req = 1'b0;
    $display("post-reset: CPU write 0010 acked");
    @(negedge clk);
    chk("rel_idle", {29'd0, bus1.Cpu_Ack, bus1.Dev_Ack, bus1.Busy} | {31'd0, bus1.Mem_Write}, 32'd0);
    @(negedge clk);
    chk("rel_dev_acks", {30'd0, bus1.Cpu_Ack, bus1.Dev_Ack}, 32'd1);
    chk("rel_dev_addr", bus1.Mem_Addr, 32'h0020);
    chk("rel_dev_wdata", bus1.Mem_WData, 32'h2222);
    bus1.Dev_Req = 1'b0;
    $display("post-reset: device write 0020 acked");
    @(negedge clk);

    // ---- CPU read of 0x0040 ----
    bus1.Cpu_Addr = 16'h0040; bus1.Cpu_Write = 1'b0; bus1.Cpu_Req = 1'b1;
    q1.push_back({1'b0, 16'hBEEF});
    @(negedge clk);
    chk("rd_ack", {30'd0, bus1.Cpu_Ack, bus1.Dev_Ack}, 32'd2);
    chk("rd_addr", bus1.Mem_Addr, 32'h0040);
    chk("rd_wr", {31'd0, bus1.Mem_Write}, 32'd0);
    bus1.Cpu_Req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid_time", {30'd0, bus1.Cpu_RValid, bus1.Dev_RValid}, 32'd2);
    $display("CPU read 0040 issued");
    @(negedge clk);

    // ---- Device write 0x1234 to 0x00FF ----
    bus1.Dev_Addr = 16'h00FF; bus1.Dev_Write = 1'b1; bus1.Dev_WData = 16'h1234; bus1.Dev_Req = 1'b1;
    @(negedge clk);
    chk("dw_ack", {30'd0, bus1.Cpu_Ack, bus1.Dev_Ack}, 32'd1);
    chk("dw_wr", {31'd0, bus1.Mem_Write}, 32'd1);
    chk("dw_wdata", bus1.Mem_WData, 32'h1234);
    chk("dw_addr", bus1.Mem_Addr, 32'h00FF);
    bus1.Dev_Req = 1'b0;
    @(negedge clk);
    chk("dw_wr_off", {31'd0, bus1.Mem_Write}, 32'd0);
    chk("dw_no_rv", {30'd0, bus1.Cpu_RValid, bus1.Dev_RValid}, 32'd0);
    $display("device write 00FF=1234 done");
    @(negedge clk);

    // ---- Simultaneous single-shot requests ----
    bus1.Cpu_Addr = 16'h0030; bus1.Cpu_Write = 1'b1; bus1.Cpu_WData = 16'hA5A5; bus1.Cpu_Req = 1'b1;
    bus1.Dev_Addr = 16'h0031; bus1.Dev_Write = 1'b1; bus1.Dev_WData = 16'h5A5A; bus1.Dev_Req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("both_acks_k%0d", k), {30'd0, bus1.Cpu_Ack, bus1.Dev_Ack},
          (k == 1) ? 32'd2 : ((k == 3) ? 32'd1 : 32'd0));
      if (bus1.Cpu_Ack) bus1.Cpu_Req = 1'b0;
      if (bus1.Dev_Ack) bus1.Dev_Req = 1'b0;
    end
    bus1.Cpu_Req = 1'b0;
    bus1.Dev_Req = 1'b0;
    $display("simultaneous requests done");
    @(negedge clk);

    // ---- Continuous CPU traffic against a device read ----
    bus1.Cpu_Addr = 16'h0100; bus1.Cpu_Write = 1'b1; bus1.Cpu_WData = 16'h5555; bus1.Cpu_Req = 1'b1;
    bus1.Dev_Addr = 16'h0040; bus1.Dev_Write = 1'b0; bus1.Dev_Req = 1'b1;
    q1.push_back({1'b1, 16'hBEEF});
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
`ifdef MEM_ARB_RR_EN
      exp_cpu = (k % 2 == 1) && (k != 3);
      exp_dev = (k == 3);
`else
      exp_cpu = (k % 2 == 1) && (k <= 7);
      exp_dev = (k == 9);
      if (k == 7) chk("starve_full", 32'(u_dut.starve_cnt_reg), 32'd4);
      if (k == 9) chk("starve_clear", 32'(u_dut.starve_cnt_reg), 32'd0);
`endif
      chk($sformatf("starve_acks_k%0d", k), {30'd0, bus1.Cpu_Ack, bus1.Dev_Ack},
          {30'd0, exp_cpu, exp_dev});
      if (bus1.Dev_Ack) bus1.Dev_Req = 1'b0;
    end
    bus1.Cpu_Req = 1'b0;
    bus1.Dev_Req = 1'b0;
    $display("starvation sequence done");
    repeat (3) @(negedge clk);

    // ---- READ_LAT=2: ordered, tagged returns ----
    rst2 = 1'b0;
    @(negedge clk);
    bus2.Cpu_Addr = 16'h0040; bus2.Cpu_Write = 1'b0; bus2.Cpu_Req = 1'b1;
    bus2.Dev_Addr = 16'h0041; bus2.Dev_Write = 1'b0; bus2.Dev_Req = 1'b1;
    q2.push_back({1'b0, 16'hBEEF});
    q2.push_back({1'b1, 16'hCAFE});
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("lat2_acks_k%0d", k), {30'd0, bus2.Cpu_Ack, bus2.Dev_Ack},
          (k == 1) ? 32'd2 : ((k == 3) ? 32'd1 : 32'd0));
      chk($sformatf("lat2_rv_k%0d", k), {30'd0, bus2.Cpu_RValid, bus2.Dev_RValid},
          (k == 3) ? 32'd2 : ((k == 5) ? 32'd1 : 32'd0));
      if (bus2.Cpu_Ack) bus2.Cpu_Req = 1'b0;
      if (bus2.Dev_Ack) bus2.Dev_Req = 1'b0;
    end
    bus2.Cpu_Req = 1'b0;
    bus2.Dev_Req = 1'b0;
    $display("READ_LAT=2 ordered reads done");
    @(negedge clk);

    // ---- Reset during ACCESS discards the in-flight read ----
    bus2.Cpu_Addr = 16'h0040; bus2.Cpu_Write = 1'b0; bus2.Cpu_Req = 1'b1;
    @(negedge clk);
    chk("rstmid_ack", {30'd0, bus2.Cpu_Ack, bus2.Busy}, 32'd3);
    rst2 = 1'b1;
    bus2.Cpu_Req = 1'b0;
    @(negedge clk);
    chk("rstmid_idle", {29'd0, bus2.Busy, bus2.Mem_Write, bus2.Cpu_Ack}, 32'd0);
    rst2 = 1'b0;
    for (int k = 3; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("rstmid_no_rv_k%0d", k), {30'd0, bus2.Cpu_RValid, bus2.Dev_RValid}, 32'd0);
    end
    $display("reset mid-access done");

    repeat (3) @(negedge clk);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
